pll_reset_sequencer: RTL and testbench

Reset and lock supervisor on the consumer side of the 25 MHz PLL. It runs on the PLL output clock and synchronises and debounces the PLL `locked` indication. It holds the game logic (video timing, CPU, sound) in reset until lock has been stable long enough, then releases reset. It re-asserts reset immediately on loss of lock, counts lock-loss events and flags lock-acquisition timeouts for the debug LEDs.

---
 rtl/pll_rst_pkg.sv | 16 +
 rtl/sync2.sv | 25 ++
 rtl/pll_reset_sequencer.sv | 108 ++++++++++
 tb/tb_pll_reset_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pll_rst_pkg.sv
// Shared types and default constants for the PLL reset sequencer.
// The state encodings are visible on the debug port, so their values are fixed.
package pll_rst_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    STABLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } pll_state_t;

  localparam int LOCK_STABLE_DEF  = 16;
  localparam int RESET_HOLD_DEF   = 8;
  localparam int LOCK_TIMEOUT_DEF = 2500000;

endpackage

// File: rtl/sync2.sv
// Two-flop synchroniser for a single asynchronous level input.
// Both flops clear on a synchronous active-high reset.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic sync_p0;
  logic sync_p1;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
    end else begin
      sync_p0 <= d;
      sync_p1 <= sync_p0;
    end
  end

  assign q = sync_p1;

endmodule

// File: rtl/pll_reset_sequencer.sv
// Supervises PLL lock: debounces locked, holds downstream reset until lock is
// stable, drops back on loss, counts lock losses and flags acquisition timeouts.
module pll_reset_sequencer
  import pll_rst_pkg::*;
#(
  parameter int LOCK_STABLE  = LOCK_STABLE_DEF,
  parameter int RESET_HOLD   = RESET_HOLD_DEF,
  parameter int LOCK_TIMEOUT = LOCK_TIMEOUT_DEF,
  parameter int CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  output logic             sys_reset,
  output logic             sys_ready,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] lock_lost_count,
  output logic             lock_timeout
);

  localparam int CNT_MAX = (LOCK_STABLE > RESET_HOLD) ? LOCK_STABLE : RESET_HOLD;
  localparam int CW      = $clog2(CNT_MAX);
  localparam int TW      = $clog2(LOCK_TIMEOUT);

  localparam logic [CW-1:0] STABLE_LAST  = CW'(LOCK_STABLE - 1);
  localparam logic [CW-1:0] HOLD_LAST    = CW'(RESET_HOLD - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(LOCK_TIMEOUT - 1);

  logic             locked_s;
  pll_state_t       state_q;
  logic [CW-1:0]    cnt;
  logic [TW-1:0]    tcnt;
  logic [CNT_W-1:0] lost_cnt;
  logic             timeout_q;

  sync2 u_lock_sync (
    .clk (clk),
    .rst (reset),
    .d   (pll_locked),
    .q   (locked_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= WAIT_LOCK;
      cnt       <= '0;
      tcnt      <= '0;
      lost_cnt  <= '0;
      timeout_q <= 1'b0;
    end else begin
      case (state_q)
        WAIT_LOCK: begin
          if (locked_s) begin
            state_q <= STABLE;
            cnt     <= '0;
          end
        end
        STABLE: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
          end else if (cnt == STABLE_LAST) begin
            state_q <= HOLD;
            cnt     <= '0;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        HOLD: begin
          // A drop here is still part of acquisition, so it is not counted as a loss.
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
          end else if (cnt == HOLD_LAST) begin
            state_q <= RUN;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        RUN: begin
          if (!locked_s) begin
            state_q <= WAIT_LOCK;
            if (lost_cnt != '1) begin
              lost_cnt <= lost_cnt + CNT_W'(1);
            end
          end
        end
        default: state_q <= WAIT_LOCK;
      endcase

      // Timeout tracks total time spent acquiring; it pins at its terminal value.
      if (state_q == WAIT_LOCK || state_q == STABLE) begin
        if (tcnt == TIMEOUT_LAST) begin
          timeout_q <= 1'b1;
        end else begin
          tcnt <= tcnt + TW'(1);
        end
      end else begin
        tcnt <= '0;
      end
    end
  end

  assign sys_reset       = (state_q != RUN);
  assign sys_ready       = (state_q == RUN);
  assign state           = state_q;
  assign lock_lost_count = lost_cnt;
  assign lock_timeout    = timeout_q;

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: vector table plus hand-written
// multi-cycle sequences for glitch, coincident events, saturation and mid-HOLD reset.
module tb_pll_reset_sequencer;

  localparam int LS = 16;
  localparam int RH = 8;
  localparam int LT = 100;
  localparam int CW = 8;

  logic          clk;
  logic          reset;
  logic          pll_locked;
  logic          sys_reset;
  logic          sys_ready;
  logic [1:0]    state;
  logic [CW-1:0] lock_lost_count;
  logic          lock_timeout;

  int n_tests;
  int n_fail;

  typedef struct {
    string name;
    logic  rst;
    logic  lock;
    int    cycles;
    int    exp_state;
    int    exp_lost;
    int    exp_to;
  } vec_t;

  vec_t vecs[$];

  pll_reset_sequencer #(
    .LOCK_STABLE  (LS),
    .RESET_HOLD   (RH),
    .LOCK_TIMEOUT (LT),
    .CNT_W        (CW)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .pll_locked      (pll_locked),
    .sys_reset       (sys_reset),
    .sys_ready       (sys_ready),
    .state           (state),
    .lock_lost_count (lock_lost_count),
    .lock_timeout    (lock_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check(input string name, input int act, input int req);
    n_tests++;
    if (act != req) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic check_all(input string name, input int st, input int lost, input int to);
    check({name, ".state"}, int'(state), st);
    check({name, ".sys_reset"}, int'(sys_reset), (st != 3) ? 1 : 0);
    check({name, ".sys_ready"}, int'(sys_ready), (st == 3) ? 1 : 0);
    check({name, ".lost"}, int'(lock_lost_count), lost);
    check({name, ".timeout"}, int'(lock_timeout), to);
  endtask

  task automatic add(input string name, input logic r, input logic l, input int c,
                     input int st, input int lost, input int to);
    vec_t v;
    v.name = name; v.rst = r; v.lock = l; v.cycles = c;
    v.exp_state = st; v.exp_lost = lost; v.exp_to = to;
    vecs.push_back(v);
  endtask

  initial begin
    int bad;
    int model_lost;
    n_tests = 0;
    n_fail  = 0;
    reset      = 1'b1;
    pll_locked = 1'b0;

    // Clean lock: edge k is the first tick after lock is raised; RUN at k+26.
    add("reset",       1, 0, 3,  0, 0, 0);
    add("lock_k1",     0, 1, 2,  0, 0, 0);
    add("lock_k2",     0, 1, 1,  1, 0, 0);
    add("lock_k17",    0, 1, 15, 1, 0, 0);
    add("lock_k18",    0, 1, 1,  2, 0, 0);
    add("lock_k25",    0, 1, 7,  2, 0, 0);
    add("lock_k26",    0, 1, 1,  3, 0, 0);
    // Loss in RUN: sampled low at j, reset rises at j+2.
    add("loss_j",      0, 0, 1,  3, 0, 0);
    add("loss_j1",     0, 0, 1,  3, 0, 0);
    add("loss_j2",     0, 0, 1,  0, 1, 0);
    add("relock_k25",  0, 1, 26, 2, 1, 0);
    add("relock_k26",  0, 1, 1,  3, 1, 0);
    // Timeout with lock held low after reset release.
    add("to_reset",    1, 0, 1,  0, 0, 0);
    add("to_edge99",   0, 0, 99, 0, 0, 0);
    add("to_edge100",  0, 0, 1,  0, 0, 1);
    add("to_sticky",   0, 1, 27, 3, 0, 1);
    add("to_cleared",  1, 1, 1,  0, 0, 0);
    add("to_rel",      0, 0, 2,  0, 0, 0);

    foreach (vecs[i]) begin
      reset      = vecs[i].rst;
      pll_locked = vecs[i].lock;
      tick(vecs[i].cycles);
      check_all(vecs[i].name, vecs[i].exp_state, vecs[i].exp_lost, vecs[i].exp_to);
    end

    // Glitch in STABLE: one low sample restarts the full sequence.
    pll_locked = 1'b1;
    tick(12);
    check_all("glitch_pre", 1, 0, 0);
    pll_locked = 1'b0;
    tick(1);
    pll_locked = 1'b1;
    tick(1);
    check_all("glitch_g1", 1, 0, 0);
    tick(1);
    check_all("glitch_g2", 0, 0, 0);
    bad = 0;
    for (int i = 0; i < 24; i++) begin
      tick(1);
      if (sys_reset !== 1'b1) bad++;
    end
    check("glitch_sys_reset_held", bad, 0);
    tick(1);
    check_all("glitch_run", 3, 0, 0);

    // Loss coinciding with terminal HOLD count: loss wins, not counted.
    pll_locked = 1'b0;
    tick(3);
    check_all("coinc_loss", 0, 1, 0);
    pll_locked = 1'b1;
    tick(24);
    pll_locked = 1'b0;
    tick(2);
    check_all("coinc_hold_last", 2, 1, 0);
    tick(1);
    check_all("coinc_wait", 0, 1, 0);

    // Saturation of the loss counter.
    model_lost = 1;
    bad = 0;
    for (int i = 0; i < 260; i++) begin
      pll_locked = 1'b1;
      tick(27);
      if (state !== 2'd3) bad++;
      pll_locked = 1'b0;
      tick(3);
      model_lost = (model_lost < 255) ? model_lost + 1 : 255;
      if (int'(lock_lost_count) != model_lost || state !== 2'd0) bad++;
    end
    check("sat_cycle_errors", bad, 0);
    check_all("sat_final", 0, 255, 0);

    // Reset pulse while in HOLD.
    pll_locked = 1'b1;
    tick(20);
    check_all("midhold_pre", 2, 255, 0);
    reset = 1'b1;
    tick(1);
    check_all("midhold_reset", 0, 0, 0);
    reset = 1'b0;
    tick(26);
    check_all("midhold_k25", 2, 0, 0);
    tick(1);
    check_all("midhold_run", 3, 0, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
